// File: rtl/fft_mem_pkg.sv
// Shared types and default widths for the FFT working-memory arbiter.
package fft_mem_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_CLR    = 2'd3
   } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant0,
   output logic grant1
);

   // last_grant = 1 means requester 1 was served last, so requester 0 wins a tie.
   assign grant0 = req0 & (~req1 | last_grant);
   assign grant1 = req1 & ~grant0;

endmodule

// File: rtl/fft_mem_arbiter.sv
// Arbitrates the sample loader and butterfly engine onto one single-port SRAM,
// with a one-cycle whole-memory clear that takes priority over both.
module fft_mem_arbiter
   import fft_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              r0_req,
   input  logic              r0_wen,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_ack,
   input  logic              r1_req,
   input  logic              r1_wen,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_ack,
   input  logic              clr_req,
   output logic              clr_done,
   output logic              busy,
   output logic              sram_read_enable,
   output logic              sram_write_enable,
   output logic [ADDR_W-1:0] sram_address,
   output logic [DATA_W-1:0] sram_write_data,
   output logic              sram_mem_clr,
   input  logic [DATA_W-1:0] sram_read_data
);

   state_t              state_q, state_d;
   logic                grant0, grant1;
   logic                last_grant;
   logic                winner_q;
   logic                wen_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   r0_rdata_q, r1_rdata_q;
   logic                clr_done_q;
   logic                take_grant;

   rr_pick2 u_pick (
      .req0       (r0_req),
      .req1       (r1_req),
      .last_grant (last_grant),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   assign take_grant = (state_q == ST_IDLE) && !clr_req && (grant0 || grant1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!n_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_req)               state_d = ST_CLR;
            else if (r0_req || r1_req) state_d = ST_ACCESS;
         end
         ST_ACCESS: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         ST_CLR:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         last_grant <= 1'b1;
         winner_q   <= 1'b0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         r0_rdata_q <= '0;
         r1_rdata_q <= '0;
         clr_done_q <= 1'b0;
      end else begin
         clr_done_q <= (state_q == ST_CLR);
         if (take_grant) begin
            winner_q   <= grant1;
            last_grant <= grant1;
            wen_q      <= grant1 ? r1_wen   : r0_wen;
            addr_q     <= grant1 ? r1_addr  : r0_addr;
            wdata_q    <= grant1 ? r1_wdata : r0_wdata;
         end
         // Read data is only live during ACCESS; writes never touch rdata.
         if (state_q == ST_ACCESS && !wen_q) begin
            if (winner_q) r1_rdata_q <= sram_read_data;
            else          r0_rdata_q <= sram_read_data;
         end
      end
   end

   always_comb begin
      sram_read_enable  = 1'b0;
      sram_write_enable = 1'b0;
      sram_address      = '0;
      sram_write_data   = '0;
      sram_mem_clr      = 1'b0;
      r0_ack            = 1'b0;
      r1_ack            = 1'b0;
      busy              = (state_q != ST_IDLE);
      unique case (state_q)
         ST_ACCESS: begin
            sram_read_enable  = ~wen_q;
            sram_write_enable = wen_q;
            sram_address      = addr_q;
            sram_write_data   = wdata_q;
         end
         ST_DONE: begin
            r0_ack = ~winner_q;
            r1_ack = winner_q;
         end
         ST_CLR:  sram_mem_clr = 1'b1;
         default: ;
      endcase
   end

   assign clr_done = clr_done_q;
   assign r0_rdata = r0_rdata_q;
   assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_fft_mem_arbiter.sv
// Directed bench for fft_mem_arbiter with a behavioural SRAM alongside.
module tb_fft_mem_arbiter;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        r0_req, r0_wen, r1_req, r1_wen, clr_req;
   logic [15:0] r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata;
   logic        r0_ack, r1_ack, clr_done, busy;
   logic        sram_read_enable, sram_write_enable, sram_mem_clr;
   logic [15:0] sram_address;
   logic [31:0] sram_write_data, sram_read_data;

   int passed = 0;
   int total  = 0;

   fft_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
      .clk(clk), .n_rst(n_rst),
      .r0_req(r0_req), .r0_wen(r0_wen), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_rdata(r0_rdata), .r0_ack(r0_ack),
      .r1_req(r1_req), .r1_wen(r1_wen), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_rdata(r1_rdata), .r1_ack(r1_ack),
      .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
      .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
      .sram_address(sram_address), .sram_write_data(sram_write_data),
      .sram_mem_clr(sram_mem_clr), .sram_read_data(sram_read_data)
   );

   always #5 clk = ~clk;

   // Asynchronous-read SRAM; zero-filled on the first edge.
   logic [31:0] mem [0:65535];
   bit          mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init || sram_mem_clr) begin
         for (int i = 0; i < 65536; i++) mem[i] = '0;
         mem_init = 1'b1;
      end else if (sram_write_enable) begin
         mem[sram_address] = sram_write_data;
      end
   end
   assign sram_read_data = sram_read_enable ? mem[sram_address] : 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (n_rst === 1'b1) begin
         check("en_exclusive", {31'd0, sram_read_enable && sram_write_enable}, 32'd0);
         check("clr_vs_en", {31'd0, sram_mem_clr && (sram_read_enable || sram_write_enable)}, 32'd0);
      end
   end

   task automatic drop_reqs();
      r0_req = 1'b0; r0_wen = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_wen = 1'b0; r1_addr = '0; r1_wdata = '0;
   endtask

   // One uncontended access from IDLE: ACCESS outputs, DONE ack/rdata, back to IDLE.
   task automatic run_single(input string tag, input bit who, input logic wen,
                             input logic [15:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata);
      logic exp_re, exp_we, exp_a0, exp_a1;
      exp_re = !wen;
      exp_we = wen;
      exp_a0 = !who;
      exp_a1 = who;
      if (who) begin
         r1_req = 1'b1; r1_wen = wen; r1_addr = addr; r1_wdata = wdata;
      end else begin
         r0_req = 1'b1; r0_wen = wen; r0_addr = addr; r0_wdata = wdata;
      end
      tick();
      check({tag, "_acc_re"},   sram_read_enable,  exp_re);
      check({tag, "_acc_we"},   sram_write_enable, exp_we);
      check({tag, "_acc_addr"}, sram_address,      addr);
      if (wen) check({tag, "_acc_wdata"}, sram_write_data, wdata);
      check({tag, "_acc_ack"},  {r0_ack, r1_ack},  2'b00);
      tick();
      check({tag, "_done_ack0"}, r0_ack, exp_a0);
      check({tag, "_done_ack1"}, r1_ack, exp_a1);
      check({tag, "_done_en"},   {sram_read_enable, sram_write_enable}, 2'b00);
      check({tag, "_done_rdata"}, who ? r1_rdata : r0_rdata, exp_rdata);
      drop_reqs();
      tick();
      check({tag, "_idle"}, {busy, r0_ack, r1_ack}, 3'b000);
   endtask

   initial begin
      n_rst = 1'b0; clr_req = 1'b0;
      drop_reqs();
      tick(); tick();
      check("rst_busy",  busy, 1'b0);
      check("rst_ctl",   {r0_ack, r1_ack, clr_done, sram_read_enable,
                          sram_write_enable, sram_mem_clr}, 6'd0);
      check("rst_addr",  sram_address, 16'h0);
      check("rst_rdata", r0_rdata | r1_rdata, 32'h0);
      n_rst = 1'b1;
      tick();

      // Write then read back through requester 0.
      run_single("r0_wr10", 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0);
      run_single("r0_rd10", 1'b0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF);

      // Requester 1 read, then requester 0 overwrites the same word.
      run_single("r0_wr04", 1'b0, 1'b1, 16'h0004, 32'hA5A5A5A5, 32'hDEADBEEF);
      run_single("r1_rd04", 1'b1, 1'b0, 16'h0004, 32'h0,        32'hA5A5A5A5);
      run_single("r0_wr04b", 1'b0, 1'b1, 16'h0004, 32'h5A5A5A5A, 32'hDEADBEEF);
      check("r1_rdata_kept", r1_rdata, 32'hA5A5A5A5);
      run_single("r1_rd04b", 1'b1, 1'b0, 16'h0004, 32'h0,        32'h5A5A5A5A);

      // Both held: r1 was served last, so r0, r1, r0, r1 with acks 3 cycles apart.
      r0_req = 1'b1; r0_wen = 1'b1; r0_addr = 16'h0020; r0_wdata = 32'h1111_0001;
      r1_req = 1'b1; r1_wen = 1'b1; r1_addr = 16'h0021; r1_wdata = 32'h2222_0002;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("tie%0d_addr", k), sram_address, (k % 2) ? 16'h0021 : 16'h0020);
         tick();
         check($sformatf("tie%0d_ack", k), {r0_ack, r1_ack}, (k % 2) ? 2'b01 : 2'b10);
         if (k == 3) drop_reqs();
         tick();
         check($sformatf("tie%0d_gap", k), {r0_ack, r1_ack}, 2'b00);
      end

      // Clear and r1 request together: clear first, then r1 reads a zeroed word.
      clr_req = 1'b1;
      r1_req = 1'b1; r1_wen = 1'b0; r1_addr = 16'h0020;
      tick();
      check("clr_pulse", {sram_mem_clr, busy, clr_done}, 3'b110);
      check("clr_en", {sram_read_enable, sram_write_enable}, 2'b00);
      clr_req = 1'b0;
      tick();
      check("clr_done", {clr_done, sram_mem_clr, busy}, 3'b100);
      tick();
      check("clr_r1_acc", {sram_read_enable, clr_done}, 2'b10);
      check("clr_r1_addr", sram_address, 16'h0020);
      tick();
      check("clr_r1_ack", {r0_ack, r1_ack}, 2'b01);
      check("clr_r1_rdata", r1_rdata, 32'h0);
      drop_reqs();
      tick();

      // Reset mid-access after an r0 grant: no ack, outputs cleared, r0 wins next tie.
      r0_req = 1'b1; r0_wen = 1'b0; r0_addr = 16'h0010;
      tick();
      check("mid_acc_re", sram_read_enable, 1'b1);
      n_rst = 1'b0;
      drop_reqs();
      tick();
      check("mid_rst_ctl", {busy, r0_ack, r1_ack, sram_read_enable,
                            sram_write_enable, sram_mem_clr, clr_done}, 7'd0);
      check("mid_rst_rdata", r0_rdata | r1_rdata, 32'h0);
      n_rst = 1'b1;
      tick();
      check("mid_rst_noack", {busy, r0_ack, r1_ack}, 3'b000);
      r0_req = 1'b1; r0_wen = 1'b0; r0_addr = 16'h0030;
      r1_req = 1'b1; r1_wen = 1'b0; r1_addr = 16'h0031;
      tick();
      check("post_rst_addr", sram_address, 16'h0030);
      tick();
      check("post_rst_ack", {r0_ack, r1_ack}, 2'b10);
      drop_reqs();
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fft_mem_arbiter.md
FFT_MEM_ARBITER -- requirements
Module: fft_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, SRAM word-address width.
REQ-002 Parameter DATA_W, 32, SRAM data width.
REQ-003 Clocking: single clock clk; reset n_rst is synchronous, active-low.
REQ-004 clk  in  1  system clock, all state rising-edge.
REQ-005 n_rst  in  1  synchronous active-low reset.
REQ-006 r0_req / r1_req  in  1  requester 0 (sample loader/unloader) / requester 1 (butterfly engine) access request.
REQ-007 r0_wen / r1_wen  in  1  1 = write, 0 = read; valid with req.
REQ-008 r0_addr / r1_addr  in  ADDR_W  word address; valid with req.
REQ-009 r0_wdata / r1_wdata  in  DATA_W  write data; valid with req.
REQ-010 r0_rdata / r1_rdata  out  DATA_W  read data; valid while matching ack=1.
REQ-011 r0_ack / r1_ack  out  1  one-cycle completion pulse.
REQ-012 clr_req  in  1  request SRAM clear; clr_done  out  1  one-cycle pulse when clear finishes.
REQ-013 busy  out  1  state != IDLE.
REQ-014 sram_read_enable, sram_write_enable  out  1; sram_address  out  ADDR_W; sram_write_data  out  DATA_W; sram_mem_clr  out  1; sram_read_data  in  DATA_W; connect to the on-chip SRAM wrapper.

Function
REQ-015 FSM states IDLE, ACCESS, DONE, CLR; one transition per clock.
REQ-016 IDLE: clr_req=1 -> CLR (priority over all requests); else any req -> latch winner's wen/addr/wdata into registers -> ACCESS; else stay.
REQ-017 ACCESS (exactly 1 cycle): sram_read_enable = ~wen_q, sram_write_enable = wen_q, sram_address = addr_q, sram_write_data = wdata_q, all from registers; sram_read_data captured into winner's rdata register at end of cycle on reads; -> DONE.
REQ-018 DONE (1 cycle): winner's ack = 1, other ack = 0, SRAM enables 0; -> IDLE.
REQ-019 CLR: sram_mem_clr = 1 for exactly 1 cycle, then clr_done = 1 for 1 cycle (state returns IDLE with clr_done pulse); requests pending during CLR wait.
REQ-020 Latency: req sampled in IDLE at cycle N -> SRAM access cycle N+1 -> ack at cycle N+2; one access per 3 cycles max.
REQ-021 Requester holds req, wen, addr, wdata stable until ack; req sampled only in IDLE; a req still high in the cycle after ack is a new request.
REQ-022 Arbitration: single req wins; both req -> winner is the requester not served last (round-robin flag last_grant updated on each grant).
REQ-023 rdata registers hold last read value until next read for that requester; writes leave rdata unchanged.
REQ-024 SRAM read_enable and write_enable never both 1; no SRAM enable outside ACCESS; sram_mem_clr only in CLR.

Reset
REQ-025 n_rst=0 at a rising edge -> state IDLE, all outputs 0, rdata registers 0, latched command 0, last_grant = 1 (requester 0 wins first tie); an in-flight access is abandoned with no ack.

Structure
REQ-026 Package fft_mem_pkg holds the state enum type and default ADDR_W/DATA_W constants.
REQ-027 One sub-module rr_pick2: combinational 2-way round-robin pick (req0, req1, last_grant -> grant0, grant1).

Verification
REQ-028 Reset, r0 write addr 0x0010 data 0xDEADBEEF -> sram_write_enable=1 at N+1, r0_ack at N+2; then r0 read 0x0010 -> r0_rdata=0xDEADBEEF with r0_ack.
REQ-029 r0_req and r1_req high together, held -> grants alternate r0, r1, r0, r1, each ack 3 cycles apart.
REQ-030 clr_req and r1_req rise same cycle in IDLE -> sram_mem_clr pulse first, clr_done, then r1 served; r1 read of a written address returns 0.
REQ-031 n_rst=0 during ACCESS -> no ack, all outputs 0 next cycle, next tie grants r0.
REQ-032 r1 read 0x0004 then r0 write 0x0004 -> r1_rdata keeps old value, sram enables never both high (assertion throughout).
